alu_mc: RTL

- Registered, multi-cycle successor to the datapath ALU, generalised to DSIZE bits, with a persistent flag register and a valid/ready input handshake.
- Adds an iterative shift-add unsigned multiply (MUL) alongside the existing single-cycle ops.
- Sits between the register-file read stage and writeback; the flag register feeds branch-condition logic.

---
 rtl/alu_mc.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle logic/shift/add ops, iterative shift-add MUL,
// persistent Z/V/N flag register and a valid/ready request handshake.
module alu_mc #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [SHW-1:0]   imm,
  input  logic             update,
  output logic [DSIZE-1:0] out,
  output logic             out_valid,
  output logic [2:0]       flag
);

  localparam int unsigned HALF = DSIZE / 2;
  localparam int unsigned DW   = 2 * DSIZE;
  localparam int unsigned CW   = $clog2(DSIZE) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_RL  = 4'd7;
  localparam logic [3:0] OP_LHB = 4'd8;
  localparam logic [3:0] OP_LLB = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [DSIZE-1:0] out_q;
  logic [2:0]       flag_q;
  logic             vld_q;
  logic             upd_q;
  logic [DW-1:0]    acc_q, mcand_q;
  logic [DSIZE-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;

  logic [DSIZE-1:0] res_d;
  logic [2:0]       flag_d;
  logic             flag_en_d;
  logic [DSIZE-1:0] sum_d, diff_d;
  logic [DW-1:0]    rot_d;
  logic [DW-1:0]    acc_d;
  logic [2:0]       mul_flag_d;

  // Single-cycle result and flag candidates from the live request inputs
  always_comb begin
    res_d     = '0;
    flag_d    = flag_q;
    flag_en_d = 1'b0;
    sum_d     = a + b;
    diff_d    = a - b;
    rot_d     = {a, a} << imm;
    case (op)
      OP_ADD: begin
        res_d     = sum_d;
        flag_en_d = 1'b1;
        flag_d    = {sum_d == '0, (a[DSIZE-1] == b[DSIZE-1]) && (sum_d[DSIZE-1] != a[DSIZE-1]),
                     sum_d[DSIZE-1]};
      end
      OP_SUB: begin
        res_d     = diff_d;
        flag_en_d = 1'b1;
        flag_d    = {diff_d == '0, (a[DSIZE-1] != b[DSIZE-1]) && (diff_d[DSIZE-1] != a[DSIZE-1]),
                     diff_d[DSIZE-1]};
      end
      OP_AND: begin
        res_d     = a & b;
        flag_en_d = 1'b1;
        flag_d    = {(a & b) == '0, 1'b0, res_d[DSIZE-1]};
      end
      OP_OR: begin
        res_d     = a | b;
        flag_en_d = 1'b1;
        flag_d    = {(a | b) == '0, 1'b0, res_d[DSIZE-1]};
      end
      OP_SLL:  res_d = a << imm;
      OP_SRL:  res_d = a >> imm;
      OP_SRA:  res_d = DSIZE'($signed(a) >>> imm);
      // Upper half of the doubled word is the rotation; imm=0 never shifts by DSIZE
      OP_RL:   res_d = rot_d[DW-1:DSIZE];
      OP_LHB:  res_d = {b[HALF-1:0], a[HALF-1:0]};
      OP_LLB:  res_d = {a[DSIZE-1:HALF], b[HALF-1:0]};
      default: res_d = '0;
    endcase
  end

  // One shift-add multiply step, including the final one that produces the result
  always_comb begin
    acc_d      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_flag_d = {acc_d[DSIZE-1:0] == '0, acc_d[DW-1:DSIZE] != '0, acc_d[DSIZE-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_q    <= '0;
      flag_q   <= '0;
      vld_q    <= 1'b0;
      upd_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state_q  <= BUSY;
              acc_q    <= '0;
              mcand_q  <= DW'(a);
              mplier_q <= b;
              cnt_q    <= CW'(DSIZE);
              upd_q    <= update;
            end else begin
              out_q <= res_d;
              vld_q <= 1'b1;
              if (update && flag_en_d) flag_q <= flag_d;
            end
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            out_q   <= acc_d[DSIZE-1:0];
            vld_q   <= 1'b1;
            if (upd_q) flag_q <= mul_flag_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = vld_q;
  assign flag      = flag_q;

endmodule
